// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   size_e    : access size codes carried on req_size
//   state_e   : responder FSM encoding
//   mem_req_t : request fields captured at the accept edge
//   be_from() : byte-enable mask for a given size and byte offset
package riscv_mem_pkg;

  localparam int NUM_LANES = 4;   // byte lanes per 32-bit word
  localparam int CNT_W     = 4;   // latency counter width (LATENCY <= 15)

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Byte enables, little-endian. Alignment is not checked here; a misaligned
  // half simply gets the pair containing the addressed byte.
  function automatic logic [NUM_LANES-1:0] be_from(input size_e size,
                                                   input logic [1:0] addr_lo);
    logic [NUM_LANES-1:0] be;
    be = '0;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between the core and a 32-bit RAM word.
//   size, addr_lo, is_unsigned : latched request attributes
//   wdata                      : right-aligned store data
//   rword                      : RAM word currently addressed
//   wdata_rep                  : store data replicated into every candidate lane
//   be                         : byte enables for the store
//   rdata_ext                  : addressed lane, right-aligned and extended
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic                 clk_unused_n, // tie-off for structural symmetry; not used
  input  size_e                size,
  input  logic [1:0]           addr_lo,
  input  logic                 is_unsigned,
  input  logic [31:0]          wdata,
  input  logic [31:0]          rword,
  output logic [31:0]          wdata_rep,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0]          rdata_ext
);

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [31:0]               shifted;
  logic                      unused;

  // Split the RAM word into byte lanes.
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lanes[g] = rword[8*g +: 8];
    end
  endgenerate

  assign unused = clk_unused_n;

  always_comb begin
    be        = be_from(size, addr_lo);
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Load: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = lanes >> {addr_lo, 3'b000};
    rdata_ext = rword;
    case (size)
      SZ_BYTE: rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_ext = rword;   // word loads ignore is_unsigned
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, served
// from an internal word-organised RAM with a fixed response latency.
//   clk, reset                     : clock, async active-low reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata: request fields, captured at accept
//   rsp_valid/rsp_ready            : response handshake, held until accepted
//   rsp_rdata, rsp_err             : extended load data / rejection flag
// rsp_valid rises exactly LATENCY edges after the accept edge. The access
// (RAM write or read capture) happens on that same edge.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  mem_req_t             lat;

  logic [31:0]          mem [DEPTH_WORDS];
  logic [AW-1:0]        widx;
  logic [31:0]          rword;
  logic [31:0]          wdata_rep;
  logic [NUM_LANES-1:0] be;
  logic [31:0]          rdata_ext;
  logic                 err_c;
  logic                 commit;

  assign widx   = lat.addr[AW+1:2];
  assign rword  = mem[widx];
  // Final WAIT cycle: this edge performs the access and raises rsp_valid.
  assign commit = (state == WAIT) && (cnt == '0);

  // Rejection check on the latched request.
  always_comb begin
    err_c = 1'b0;
    case (lat.size)
      SZ_HALF: err_c = lat.addr[0];
      SZ_WORD: err_c = |lat.addr[1:0];
      SZ_ILL:  err_c = 1'b1;
      default: err_c = 1'b0;
    endcase
    if ({2'b00, lat.addr[31:2]} >= 32'(DEPTH_WORDS)) err_c = 1'b1;
  end

  mem_lane_align u_align (
    .clk_unused_n (1'b0),
    .size         (lat.size),
    .addr_lo      (lat.addr[1:0]),
    .is_unsigned  (lat.uns),
    .wdata        (lat.wdata),
    .rword        (rword),
    .wdata_rep    (wdata_rep),
    .be           (be),
    .rdata_ext    (rdata_ext)
  );

  // RAM: no reset, contents survive reset. A reset during WAIT forces the
  // FSM to IDLE asynchronously, so commit cannot fire for a discarded store.
  always_ff @(posedge clk) begin
    if (commit && lat.we && !err_c) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat       <= '{we: req_we, size: size_e'(req_size), uns: req_unsigned,
                           addr: req_addr, wdata: req_wdata};
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= WAIT;
            req_ready <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_c;
            rsp_rdata <= (err_c || lat.we) ? 32'h0 : rdata_ext;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One full transaction: accept, count edges to rsp_valid, capture, handshake.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    int g;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // scramble inputs: the responder must not depend on them after accept
    req_valid = 1'b0; req_addr = 32'hDEAD_BEE0; req_wdata = 32'hFFFF_FFFF;
    req_we = ~we; req_unsigned = ~uns;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; #1; end
    rd = rsp_rdata; er = rsp_err;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w;

    vecs[0]  = '{"sw_10",   1'b1, 2'b10, 1'b0, 32'h10,  32'h8040_12FF, 32'h0,        1'b0};
    vecs[1]  = '{"lw_10",   1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h8040_12FF, 1'b0};
    vecs[2]  = '{"lb_10",   1'b0, 2'b00, 1'b0, 32'h10,  32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{"lbu_10",  1'b0, 2'b00, 1'b1, 32'h10,  32'h0,         32'h0000_00FF, 1'b0};
    vecs[4]  = '{"lh_12",   1'b0, 2'b01, 1'b0, 32'h12,  32'h0,         32'hFFFF_8040, 1'b0};
    vecs[5]  = '{"lhu_12",  1'b0, 2'b01, 1'b1, 32'h12,  32'h0,         32'h0000_8040, 1'b0};
    vecs[6]  = '{"lbu_13",  1'b0, 2'b00, 1'b1, 32'h13,  32'h0,         32'h0000_0080, 1'b0};
    vecs[7]  = '{"sb_11",   1'b1, 2'b00, 1'b0, 32'h11,  32'h1234_56AB, 32'h0,        1'b0};
    vecs[8]  = '{"lw_10b",  1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h8040_ABFF, 1'b0};
    vecs[9]  = '{"lw_12e",  1'b0, 2'b10, 1'b0, 32'h12,  32'h0,         32'h0,        1'b1};
    vecs[10] = '{"sh_13e",  1'b1, 2'b01, 1'b0, 32'h13,  32'h0000_DEAD, 32'h0,        1'b1};
    vecs[11] = '{"lw_400e", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,         32'h0,        1'b1};
    vecs[12] = '{"ld_ille", 1'b0, 2'b11, 1'b0, 32'h10,  32'h0,         32'h0,        1'b1};
    vecs[13] = '{"st_ille", 1'b1, 2'b11, 1'b0, 32'h10,  32'h1111_1111, 32'h0,        1'b1};
    vecs[14] = '{"lw_10c",  1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h8040_ABFF, 1'b0};
    vecs[15] = '{"sh_16",   1'b1, 2'b01, 1'b0, 32'h16,  32'h5555_BEEF, 32'h0,        1'b0};
    vecs[16] = '{"lh_16",   1'b0, 2'b01, 1'b0, 32'h16,  32'h0,         32'hFFFF_BEEF, 1'b0};
    vecs[17] = '{"lb_17",   1'b0, 2'b00, 1'b0, 32'h17,  32'h0,         32'hFFFF_FFBE, 1'b0};
    vecs[18] = '{"sb_1c",   1'b1, 2'b00, 1'b0, 32'h1C,  32'h0000_007F, 32'h0,        1'b0};
    vecs[19] = '{"lb_1c",   1'b0, 2'b00, 1'b0, 32'h1C,  32'h0,         32'h0000_007F, 1'b0};
    vecs[20] = '{"sw_3fc",  1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFE_F00D, 32'h0,        1'b0};
    vecs[21] = '{"lw_3fc",  1'b0, 2'b10, 1'b1, 32'h3FC, 32'h0,         32'hCAFE_F00D, 1'b0};

    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 0;

    // reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);

    // table-driven transactions
    for (int i = 0; i < 22; i++) begin
      txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, "_lat"},   32'(lat), 32'(LAT));
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"},   32'(er), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_drop"},  32'(rsp_valid), 32'd0);
    end

    // backpressure: hold rsp_ready low; a competing store must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'h0;   // still valid, but not ready -> ignored
    w = 0;
    while (!rsp_valid && w < 40) begin @(posedge clk); w++; #1; end
    chk("hold_lat", 32'(w), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'h8040_ABFF);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("hold_release", 32'(rsp_valid), 32'd0);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("after_hold_lw", rd, 32'h8040_ABFF);

    // reset in WAIT discards the uncommitted store
    txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A_5A5A, rd, er, lat);
    chk("sw_20_err", 32'(er), 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("lw_20_old", rd, 32'h5A5A_5A5A);
    chk("lw_20_lat", 32'(lat), 32'(LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
